// File: rtl/rv32im_wb_pkg.sv
// Shared types and constants for the Wishbone SRAM responder.
package rv32im_wb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } wb_state_e;

    // Lane-select patterns for byte, half-word and word transfers.
    localparam logic [3:0] SEL_BYTE = 4'b0001;
    localparam logic [3:0] SEL_HALF = 4'b0011;
    localparam logic [3:0] SEL_WORD = 4'b1111;

endpackage

// File: rtl/rv32im_wb_sram_slave_if.sv
// Wishbone classic bus bundle between the core memory unit and the SRAM responder.
// Signal names follow the responder's point of view.
interface rv32im_wb_sram_slave_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:2] adr_i;
    logic [XLEN-1:0] dat_i;
    logic [XLEN-1:0] dat_o;
    logic [3:0]      sel_i;
    logic            we_i;
    logic            cyc_i;
    logic            stb_i;
    logic            ack_o;
    logic            err_o;

    modport master (
        output adr_i, dat_i, sel_i, we_i, cyc_i, stb_i,
        input  dat_o, ack_o, err_o
    );

    modport slave (
        input  adr_i, dat_i, sel_i, we_i, cyc_i, stb_i,
        output dat_o, ack_o, err_o
    );
endinterface

// File: rtl/rv32im_bram_be.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// The read register is reset and only loads on a read strobe, so it doubles as
// the bus read-data register that holds until the next read.
module rv32im_bram_be #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  we_i,
    input  logic [XLEN/8-1:0]     be_i,
    input  logic [XLEN-1:0]       wdata_i,
    input  logic                  re_i,
    output logic [XLEN-1:0]       rdata_o
);
    logic [XLEN-1:0] mem_q [2**ADDR_WIDTH];
    logic [XLEN-1:0] rdata_q;

    // Byte-lane write; contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < XLEN/8; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Registered read word, cleared by reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/rv32im_wb_sram_slave.sv
// Wishbone classic responder in front of a byte-writable SRAM, with optional
// wait states and a read-only (boot ROM) mode.
//
// state  | meaning
// IDLE   | waiting for cyc & stb; request fields are latched on acceptance
// ACCESS | latched address on the RAM; wait counter runs down, then commit/read
// RESP   | one-cycle ack or err pulse; stb is ignored here
module rv32im_wb_sram_slave
    import rv32im_wb_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 0,
    parameter int READ_ONLY   = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    rv32im_wb_sram_slave_if.slave wb
);
    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES);

    wb_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [3:0]            sel_q, sel_d;
    logic                  we_q, we_d;
    logic [XLEN-1:0]       wdat_q, wdat_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;

    logic                  req_err;
    logic                  last_cycle;
    logic                  ram_we;
    logic                  ram_re;
    logic [XLEN-1:0]       ram_rdata;

    // Any address bit above the RAM depth, or a write to ROM, is refused.
    assign req_err    = (|(wb.adr_i >> ADDR_WIDTH)) || ((READ_ONLY != 0) && wb.we_i);
    assign last_cycle = (state_q == ACCESS) && wb.cyc_i && (cnt_q == '0);
    assign ram_we     = last_cycle && we_q;
    assign ram_re     = last_cycle && !we_q;

    // Next-state, latch and response decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        sel_d   = sel_q;
        we_d    = we_q;
        wdat_d  = wdat_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (wb.cyc_i && wb.stb_i) begin
                    adr_d  = wb.adr_i[ADDR_WIDTH+1:2];
                    sel_d  = wb.sel_i;
                    we_d   = wb.we_i;
                    wdat_d = wb.dat_i;
                    if (req_err) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ACCESS;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ACCESS: begin
                if (!wb.cyc_i) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = RESP;
                    ack_d   = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, latched request and registered response flags.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            wdat_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            wdat_q  <= wdat_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    rv32im_bram_be #(
        .XLEN       (XLEN),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .addr_i  (adr_q),
        .we_i    (ram_we),
        .be_i    (sel_q),
        .wdata_i (wdat_q),
        .re_i    (ram_re),
        .rdata_o (ram_rdata)
    );

    assign wb.dat_o = ram_rdata;
    assign wb.ack_o = ack_q;
    assign wb.err_o = err_q;
endmodule

// File: tb/tb_rv32im_wb_sram_slave.sv
// Bench for the Wishbone SRAM responder: instance 0 is a zero-wait RAM,
// instance 1 a three-wait read-only ROM. A word-array model predicts every
// response cycle and read word; a negedge process compares all outputs.
module tb_rv32im_wb_sram_slave;
    import rv32im_wb_pkg::*;

    localparam int XLEN  = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;
    localparam int WS0   = 0;
    localparam int WS1   = 3;
    localparam int RO0   = 0;
    localparam int RO1   = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rv32im_wb_sram_slave_if #(.XLEN(XLEN)) bus0 ();
    rv32im_wb_sram_slave_if #(.XLEN(XLEN)) bus1 ();

    logic [XLEN-1:2] adr_d [2];
    logic [31:0]     dat_d [2];
    logic [3:0]      sel_d [2];
    logic            we_d  [2];
    logic            cyc_d [2];
    logic            stb_d [2];
    logic            ack_w [2];
    logic            err_w [2];
    logic [31:0]     dat_w [2];

    assign bus0.adr_i = adr_d[0];
    assign bus0.dat_i = dat_d[0];
    assign bus0.sel_i = sel_d[0];
    assign bus0.we_i  = we_d[0];
    assign bus0.cyc_i = cyc_d[0];
    assign bus0.stb_i = stb_d[0];
    assign bus1.adr_i = adr_d[1];
    assign bus1.dat_i = dat_d[1];
    assign bus1.sel_i = sel_d[1];
    assign bus1.we_i  = we_d[1];
    assign bus1.cyc_i = cyc_d[1];
    assign bus1.stb_i = stb_d[1];
    assign ack_w[0] = bus0.ack_o;
    assign err_w[0] = bus0.err_o;
    assign dat_w[0] = bus0.dat_o;
    assign ack_w[1] = bus1.ack_o;
    assign err_w[1] = bus1.err_o;
    assign dat_w[1] = bus1.dat_o;

    rv32im_wb_sram_slave #(.XLEN(XLEN), .ADDR_WIDTH(AW), .WAIT_STATES(WS0), .READ_ONLY(RO0))
        dut0 (.clk_i(clk), .rst_n_i(rst_n), .wb(bus0.slave));
    rv32im_wb_sram_slave #(.XLEN(XLEN), .ADDR_WIDTH(AW), .WAIT_STATES(WS1), .READ_ONLY(RO1))
        dut1 (.clk_i(clk), .rst_n_i(rst_n), .wb(bus1.slave));

    // Model: memory image per instance plus the outputs expected right now.
    logic [31:0] mmem [2][DEPTH];
    logic        exp_ack [2];
    logic        exp_err [2];
    logic [31:0] exp_dat [2];
    bit          cmp_en = 1'b0;
    int          n_checks = 0;
    int          n_err = 0;

    function automatic int ws_of(input int k);
        return (k == 0) ? WS0 : WS1;
    endfunction

    function automatic bit ro_of(input int k);
        return (k == 0) ? (RO0 != 0) : (RO1 != 0);
    endfunction

    function automatic bit is_err_req(input int k, input bit we, input logic [XLEN-1:2] adr);
        return ((adr >> AW) != 0) || (ro_of(k) && we);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    // Cycle-by-cycle comparison of both responders against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("ack%0d", k), 32'(ack_w[k]), 32'(exp_ack[k]));
                chk($sformatf("err%0d", k), 32'(err_w[k]), 32'(exp_err[k]));
                chk($sformatf("dat%0d", k), dat_w[k], exp_dat[k]);
            end
        end
    end

    // One transfer on instance k, entered and left just after a rising edge
    // with the responder idle. Edge e=0 is the sampling edge. abort_at >= 0
    // drops cyc after that edge (must be within the wait window).
    task automatic xfer(input int k, input bit we, input logic [XLEN-1:2] adr,
                        input logic [3:0] sel, input logic [31:0] dat, input int abort_at,
                        output int lat, output int nack, output int nerr, output logic [31:0] rdat);
        bit   ie;
        int   resp;
        int   w;
        int   ab;
        ie   = is_err_req(k, we, adr);
        resp = ie ? 0 : ws_of(k) + 1;
        w    = int'(adr[AW+1:2]);
        ab   = ie ? -1 : abort_at;
        lat  = -1;
        nack = 0;
        nerr = 0;
        rdat = '0;
        adr_d[k] = adr;
        dat_d[k] = dat;
        sel_d[k] = sel;
        we_d[k]  = we;
        cyc_d[k] = 1'b1;
        stb_d[k] = 1'b1;
        for (int e = 0; e <= resp + 1; e++) begin
            @(posedge clk);
            #1;
            if (ack_w[k]) begin
                nack++;
                if (lat < 0) lat = e;
                rdat = dat_w[k];
            end
            if (err_w[k]) begin
                nerr++;
                if (lat < 0) lat = e;
            end
            if (ab >= 0 && e == ab + 1) break;
            if (e == 0) begin
                adr_d[k] = XLEN'($urandom) >> 2;
                dat_d[k] = $urandom;
                sel_d[k] = 4'($urandom);
                we_d[k]  = 1'($urandom);
            end
            if (ab >= 0 && e == ab) begin
                cyc_d[k] = 1'b0;
                stb_d[k] = 1'b0;
            end
            if (e == resp) begin
                exp_ack[k] = !ie;
                exp_err[k] = ie;
                if (!ie && we) begin
                    for (int b = 0; b < 4; b++)
                        if (sel[b]) mmem[k][w][8*b +: 8] = dat[8*b +: 8];
                end
                if (!ie && !we) exp_dat[k] = mmem[k][w];
            end
            if (e == resp + 1) begin
                exp_ack[k] = 1'b0;
                exp_err[k] = 1'b0;
                cyc_d[k]   = 1'b0;
                stb_d[k]   = 1'b0;
            end
        end
    endtask

    task automatic rand_run(input int k, input int n);
        int               lat, na, ne, ab;
        logic [31:0]      rd;
        bit               we;
        logic [XLEN-1:2]  adr;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            we = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       adr = (XLEN-2)'($urandom) | (XLEN-2)'(DEPTH);
                1:       adr = (XLEN-2)'($urandom_range(0, DEPTH - 1));
                default: adr = (XLEN-2)'($urandom_range(0, 31));
            endcase
            ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, ws_of(k))) : -1;
            xfer(k, we, adr, 4'($urandom), $urandom, ab, lat, na, ne, rd);
            chk($sformatf("rand_nresp%0d", k), 32'(na + ne),
                (ab >= 0 && !is_err_req(k, we, adr)) ? 32'd0 : 32'd1);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, na, ne;
        logic [31:0] rd;
        for (int k = 0; k < 2; k++) begin
            adr_d[k] = '0; dat_d[k] = '0; sel_d[k] = '0; we_d[k] = 1'b0;
            cyc_d[k] = 1'b0; stb_d[k] = 1'b0;
            exp_ack[k] = 1'b0; exp_err[k] = 1'b0; exp_dat[k] = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            mmem[0][i] = $urandom;
            mmem[1][i] = $urandom;
        end
        mmem[1][5] = 32'hCAFE_F00D;
        for (int i = 0; i < DEPTH; i++) begin
            dut0.u_ram.mem_q[i] = mmem[0][i];
            dut1.u_ram.mem_q[i] = mmem[1][i];
        end

        #2;
        chk("reset_ack0", 32'(ack_w[0]), 32'd0);
        chk("reset_dat0", dat_w[0], 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        cmp_en = 1'b1;

        // Read after write, zero wait states.
        xfer(0, 1'b1, 30'h004, SEL_WORD, 32'hDEAD_BEEF, -1, lat, na, ne, rd);
        chk("raw_wr_lat", 32'(lat), 32'd1);
        chk("raw_wr_nack", 32'(na), 32'd1);
        xfer(0, 1'b0, 30'h004, 4'b0000, 32'h0, -1, lat, na, ne, rd);
        chk("raw_rd_lat", 32'(lat), 32'd1);
        chk("raw_rd_data", rd, 32'hDEAD_BEEF);

        // Byte lanes.
        xfer(0, 1'b1, 30'h010, SEL_WORD, 32'h1122_3344, -1, lat, na, ne, rd);
        xfer(0, 1'b1, 30'h010, 4'b0100, 32'hAABB_CCDD, -1, lat, na, ne, rd);
        xfer(0, 1'b0, 30'h010, SEL_WORD, 32'h0, -1, lat, na, ne, rd);
        chk("lane_byte", rd, 32'h11BB_3344);
        xfer(0, 1'b1, 30'h010, 4'b1100, 32'h5566_0000, -1, lat, na, ne, rd);
        xfer(0, 1'b0, 30'h010, 4'b0001, 32'h0, -1, lat, na, ne, rd);
        chk("lane_half", rd, 32'h5566_3344);
        xfer(0, 1'b1, 30'h010, 4'b0000, 32'hFFFF_FFFF, -1, lat, na, ne, rd);
        chk("sel0_nack", 32'(na), 32'd1);
        xfer(0, 1'b0, 30'h010, SEL_WORD, 32'h0, -1, lat, na, ne, rd);
        chk("sel0_data", rd, 32'h5566_3344);

        // Range error.
        xfer(0, 1'b1, 30'h000, SEL_WORD, 32'h0BAD_C0DE, -1, lat, na, ne, rd);
        xfer(0, 1'b0, 30'h400, SEL_WORD, 32'h0, -1, lat, na, ne, rd);
        chk("range_rd_nerr", 32'(ne), 32'd1);
        chk("range_rd_nack", 32'(na), 32'd0);
        chk("range_rd_lat", 32'(lat), 32'd0);
        xfer(0, 1'b1, 30'h400, SEL_WORD, 32'h1234_ABCD, -1, lat, na, ne, rd);
        chk("range_wr_nerr", 32'(ne), 32'd1);
        xfer(0, 1'b0, 30'h000, SEL_WORD, 32'h0, -1, lat, na, ne, rd);
        chk("range_word0", rd, 32'h0BAD_C0DE);

        // Abort a write on the zero-wait RAM.
        xfer(0, 1'b1, 30'h020, SEL_WORD, 32'h1234_5678, -1, lat, na, ne, rd);
        xfer(0, 1'b1, 30'h004, SEL_WORD, 32'h0000_0000, 0, lat, na, ne, rd);
        chk("abort_wr_nresp", 32'(na + ne), 32'd0);
        xfer(0, 1'b0, 30'h004, SEL_WORD, 32'h0, -1, lat, na, ne, rd);
        chk("abort_wr_data", rd, 32'hDEAD_BEEF);

        // Wait states and read-only behaviour on instance 1.
        xfer(1, 1'b0, 30'h005, SEL_WORD, 32'h0, -1, lat, na, ne, rd);
        chk("ws3_lat", 32'(lat), 32'd4);
        chk("ws3_nack", 32'(na), 32'd1);
        chk("ws3_data", rd, 32'hCAFE_F00D);
        xfer(1, 1'b1, 30'h005, SEL_WORD, 32'h0, -1, lat, na, ne, rd);
        chk("ro_wr_nerr", 32'(ne), 32'd1);
        chk("ro_wr_lat", 32'(lat), 32'd0);
        xfer(1, 1'b0, 30'h005, SEL_WORD, 32'h0, -1, lat, na, ne, rd);
        chk("ro_unchanged", rd, 32'hCAFE_F00D);
        xfer(1, 1'b0, 30'h006, SEL_WORD, 32'h0, 2, lat, na, ne, rd);
        chk("abort_rd_nresp", 32'(na + ne), 32'd0);
        xfer(1, 1'b0, 30'h005, SEL_WORD, 32'h0, -1, lat, na, ne, rd);
        chk("post_abort_lat", 32'(lat), 32'd4);

        // Async reset: instance 1 in its ack cycle, instance 0 with a write in ACCESS.
        adr_d[1] = 30'h007; we_d[1] = 1'b0; sel_d[1] = SEL_WORD;
        cyc_d[1] = 1'b1; stb_d[1] = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        adr_d[0] = 30'h020; dat_d[0] = 32'hFFFF_FFFF; sel_d[0] = SEL_WORD; we_d[0] = 1'b1;
        cyc_d[0] = 1'b1; stb_d[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_pre_ack1", 32'(ack_w[1]), 32'd1);
        #2;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            exp_ack[k] = 1'b0; exp_err[k] = 1'b0; exp_dat[k] = '0;
        end
        #1;
        chk("rst_ack1", 32'(ack_w[1]), 32'd0);
        chk("rst_dat1", dat_w[1], 32'd0);
        chk("rst_ack0", 32'(ack_w[0]), 32'd0);
        cyc_d[0] = 1'b0; stb_d[0] = 1'b0;
        cyc_d[1] = 1'b0; stb_d[1] = 1'b0;
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        xfer(0, 1'b0, 30'h020, SEL_WORD, 32'h0, -1, lat, na, ne, rd);
        chk("rst_no_write", rd, 32'h1234_5678);

        // Randomised traffic on both instances concurrently.
        fork
            rand_run(0, 250);
            rand_run(1, 120);
        join

        @(posedge clk);
        #1;
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
